// File: rtl/jump_sequencer.sv
// rtl/jump_sequencer.sv - PC sequencer for MIPS J/JAL/JR/JALR with link write and error pulses.
// Optional MIPS branch-delay-slot behaviour is enabled by defining JUMP_DELAY_SLOT_EN.
module jump_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        instr_valid,
    input  logic        stall,
    input  logic [31:0] instr,
    input  logic [31:0] rs_value,
    output logic [31:0] pc,
    output logic        link_we,
    output logic [4:0]  link_addr,
    output logic [31:0] link_data,
    output logic        jump_taken,
    output logic        align_err,
    output logic        slot_err
);
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    logic [31:0] pc_q, pc_d;
    logic        link_we_q, link_we_d;
    logic [4:0]  link_addr_q, link_addr_d;
    logic [31:0] link_data_q, link_data_d;
    logic        jump_taken_q, jump_taken_d;
    logic        align_err_q, align_err_d;

    logic        accept;
    logic        is_j, is_jal, is_jr, is_jalr, is_jump_class, is_link;
    logic        misaligned, valid_jump;
    logic [31:0] pc_plus4, index_target, target;
    logic [4:0]  new_link_addr;

    always_comb begin
        accept        = instr_valid && !stall;
        is_j          = (instr[31:26] == OP_J);
        is_jal        = (instr[31:26] == OP_JAL);
        is_jr         = (instr[31:26] == OP_SPECIAL) && (instr[5:0] == FN_JR);
        is_jalr       = (instr[31:26] == OP_SPECIAL) && (instr[5:0] == FN_JALR);
        is_jump_class = is_j || is_jal || is_jr || is_jalr;
        is_link       = is_jal || is_jalr;
        misaligned    = (is_jr || is_jalr) && (rs_value[1:0] != 2'b00);
        valid_jump    = is_jump_class && !misaligned;
        pc_plus4      = pc_q + 32'd4;
        // Region bits come from PC+4, not PC, so a jump in the last word of a region leaves it.
        index_target  = {pc_plus4[31:28], instr[25:0], 2'b00};
        target        = (is_jr || is_jalr) ? rs_value : index_target;
        new_link_addr = is_jal ? 5'd31 : instr[15:11];
    end

`ifdef JUMP_DELAY_SLOT_EN
    typedef enum logic {RUN = 1'b0, SLOT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] pending_q, pending_d;
    logic        slot_err_q, slot_err_d;
    logic [31:0] pc_plus8;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                RUN:     if (valid_jump) state_d = SLOT;
                SLOT:    state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        pc_plus8     = pc_q + 32'd8;
        pc_d         = pc_q;
        pending_d    = pending_q;
        link_we_d    = 1'b0;
        link_addr_d  = link_addr_q;
        link_data_d  = link_data_q;
        jump_taken_d = 1'b0;
        align_err_d  = 1'b0;
        slot_err_d   = 1'b0;
        if (accept) begin
            if (state_q == SLOT) begin
                // Slot instruction executes as sequential work; any jump in it is squashed.
                pc_d         = pending_q;
                jump_taken_d = 1'b1;
                slot_err_d   = is_jump_class;
            end else begin
                pc_d        = pc_plus4;
                align_err_d = misaligned;
                if (valid_jump) begin
                    pending_d = target;
                    if (is_link) begin
                        link_we_d   = 1'b1;
                        link_addr_d = new_link_addr;
                        link_data_d = pc_plus8;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= 32'd0;
            slot_err_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            slot_err_q <= slot_err_d;
        end
    end

    assign slot_err = slot_err_q;
`else
    always_comb begin
        pc_d         = pc_q;
        link_we_d    = 1'b0;
        link_addr_d  = link_addr_q;
        link_data_d  = link_data_q;
        jump_taken_d = 1'b0;
        align_err_d  = 1'b0;
        if (accept) begin
            if (valid_jump) begin
                pc_d         = target;
                jump_taken_d = 1'b1;
                if (is_link) begin
                    link_we_d   = 1'b1;
                    link_addr_d = new_link_addr;
                    link_data_d = pc_plus4;
                end
            end else begin
                pc_d        = pc_plus4;
                align_err_d = misaligned;
            end
        end
    end

    assign slot_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q         <= RESET_PC;
            link_we_q    <= 1'b0;
            link_addr_q  <= 5'd0;
            link_data_q  <= 32'd0;
            jump_taken_q <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            link_we_q    <= link_we_d;
            link_addr_q  <= link_addr_d;
            link_data_q  <= link_data_d;
            jump_taken_q <= jump_taken_d;
            align_err_q  <= align_err_d;
        end
    end

    assign pc         = pc_q;
    assign link_we    = link_we_q;
    assign link_addr  = link_addr_q;
    assign link_data  = link_data_q;
    assign jump_taken = jump_taken_q;
    assign align_err  = align_err_q;
endmodule

// File: tb/tb_jump_sequencer.sv
// tb/tb_jump_sequencer.sv - directed scoreboard bench for jump_sequencer (either JUMP_DELAY_SLOT_EN build).
module tb_jump_sequencer;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] instr = 32'd0;
    logic [31:0] rs_value = 32'd0;
    logic [31:0] pc;
    logic        link_we;
    logic [4:0]  link_addr;
    logic [31:0] link_data;
    logic        jump_taken;
    logic        align_err;
    logic        slot_err;

    jump_sequencer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .instr_valid(instr_valid),
        .stall      (stall),
        .instr      (instr),
        .rs_value   (rs_value),
        .pc         (pc),
        .link_we    (link_we),
        .link_addr  (link_addr),
        .link_data  (link_data),
        .jump_taken (jump_taken),
        .align_err  (align_err),
        .slot_err   (slot_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic        lwe;
        logic [4:0]  laddr;
        logic [31:0] ldata;
        logic        jt;
        logic        ae;
        logic        se;
    } exp_t;

    exp_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [31:0] epc, input logic elwe, input logic [4:0] ela,
                        input logic [31:0] eld, input logic ejt, input logic eae, input logic ese);
        exp_t e;
        e.pc = epc; e.lwe = elwe; e.laddr = ela; e.ldata = eld;
        e.jt = ejt; e.ae = eae; e.se = ese;
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            cmp({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            cmp({tag, "_pc"}, pc, e.pc);
            cmp({tag, "_link_we"}, {31'd0, link_we}, {31'd0, e.lwe});
            cmp({tag, "_link_addr"}, {27'd0, link_addr}, {27'd0, e.laddr});
            cmp({tag, "_link_data"}, link_data, e.ldata);
            cmp({tag, "_jump_taken"}, {31'd0, jump_taken}, {31'd0, e.jt});
            cmp({tag, "_align_err"}, {31'd0, align_err}, {31'd0, e.ae});
            cmp({tag, "_slot_err"}, {31'd0, slot_err}, {31'd0, e.se});
        end
    endtask

    task automatic step(input string tag, input logic v, input logic s, input logic [31:0] ins,
                        input logic [31:0] rs, input logic [31:0] epc, input logic elwe,
                        input logic [4:0] ela, input logic [31:0] eld, input logic ejt,
                        input logic eae, input logic ese);
        instr_valid = v; stall = s; instr = ins; rs_value = rs;
        push(epc, elwe, ela, eld, ejt, eae, ese);
        @(posedge clock);
        #1;
        check(tag);
    endtask

    initial begin
        #12;
        push(32'h0040_0000, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        check("reset");
        @(negedge clock);
        reset_n = 1'b1;

        step("nop0", 1, 0, NOP, 0, 32'h0040_0004, 0, 5'd0, 32'd0, 0, 0, 0);
        step("nop1", 1, 0, NOP, 0, 32'h0040_0008, 0, 5'd0, 32'd0, 0, 0, 0);
`ifdef JUMP_DELAY_SLOT_EN
        step("jal",      1, 0, 32'h0C10_0000, 0, 32'h0040_000C, 1, 5'd31, 32'h0040_0010, 0, 0, 0);
        step("jal_slot", 1, 0, NOP, 0, 32'h0040_0000, 0, 5'd31, 32'h0040_0010, 1, 0, 0);
        step("stall",    1, 1, 32'h0800_0000, 0, 32'h0040_0000, 0, 5'd31, 32'h0040_0010, 0, 0, 0);
        step("invalid",  0, 0, 32'h0800_0000, 0, 32'h0040_0000, 0, 5'd31, 32'h0040_0010, 0, 0, 0);
        step("jr_mis",   1, 0, 32'h0000_0008, 32'h0040_0102, 32'h0040_0004, 0, 5'd31, 32'h0040_0010, 0, 1, 0);
        step("jr",       1, 0, 32'h0000_0008, 32'h0FFF_FFFC, 32'h0040_0008, 0, 5'd31, 32'h0040_0010, 0, 0, 0);
        step("jr_slot",  1, 0, NOP, 0, 32'h0FFF_FFFC, 0, 5'd31, 32'h0040_0010, 1, 0, 0);
        step("j_region", 1, 0, 32'h0800_0000, 0, 32'h1000_0000, 0, 5'd31, 32'h0040_0010, 0, 0, 0);
        step("j_slot",   1, 0, NOP, 0, 32'h1000_0000, 0, 5'd31, 32'h0040_0010, 1, 0, 0);
        step("jalr_rd0", 1, 0, 32'h0000_0009, 32'h0040_0020, 32'h1000_0004, 1, 5'd0, 32'h1000_0008, 0, 0, 0);
        step("jalr_slot",1, 0, NOP, 0, 32'h0040_0020, 0, 5'd0, 32'h1000_0008, 1, 0, 0);
        step("jr_top",   1, 0, 32'h0000_0008, 32'hFFFF_FFFC, 32'h0040_0024, 0, 5'd0, 32'h1000_0008, 0, 0, 0);
        step("top_slot", 1, 0, NOP, 0, 32'hFFFF_FFFC, 0, 5'd0, 32'h1000_0008, 1, 0, 0);
        step("wrap",     1, 0, NOP, 0, 32'h0000_0000, 0, 5'd0, 32'h1000_0008, 0, 0, 0);
        step("j_a",      1, 0, 32'h0810_0010, 0, 32'h0000_0004, 0, 5'd0, 32'h1000_0008, 0, 0, 0);
        step("jal_in_slot", 1, 0, 32'h0C10_0000, 0, 32'h0040_0040, 0, 5'd0, 32'h1000_0008, 1, 0, 1);
        step("j_b",      1, 0, 32'h0810_0020, 0, 32'h0040_0044, 0, 5'd0, 32'h1000_0008, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step("slot_stall", 1, 1, NOP, 0, 32'h0040_0044, 0, 5'd0, 32'h1000_0008, 0, 0, 0);
        step("slot_release", 1, 0, NOP, 0, 32'h0040_0080, 0, 5'd0, 32'h1000_0008, 1, 0, 0);
        step("j_c",      1, 0, 32'h0810_0000, 0, 32'h0040_0084, 0, 5'd0, 32'h1000_0008, 0, 0, 0);
`else
        step("jal",      1, 0, 32'h0C10_0000, 0, 32'h0040_0000, 1, 5'd31, 32'h0040_000C, 1, 0, 0);
        step("stall",    1, 1, 32'h0800_0000, 0, 32'h0040_0000, 0, 5'd31, 32'h0040_000C, 0, 0, 0);
        step("invalid",  0, 0, 32'h0800_0000, 0, 32'h0040_0000, 0, 5'd31, 32'h0040_000C, 0, 0, 0);
        step("jr_mis",   1, 0, 32'h0000_0008, 32'h0040_0102, 32'h0040_0004, 0, 5'd31, 32'h0040_000C, 0, 1, 0);
        step("jr",       1, 0, 32'h0000_0008, 32'h0FFF_FFFC, 32'h0FFF_FFFC, 0, 5'd31, 32'h0040_000C, 1, 0, 0);
        step("j_region", 1, 0, 32'h0800_0000, 0, 32'h1000_0000, 0, 5'd31, 32'h0040_000C, 1, 0, 0);
        step("jalr_rd0", 1, 0, 32'h0000_0009, 32'h0040_0020, 32'h0040_0020, 1, 5'd0, 32'h1000_0004, 1, 0, 0);
        step("jr_top",   1, 0, 32'h0000_0008, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 5'd0, 32'h1000_0004, 1, 0, 0);
        step("wrap",     1, 0, NOP, 0, 32'h0000_0000, 0, 5'd0, 32'h1000_0004, 0, 0, 0);
        step("j_c",      1, 0, 32'h0810_0020, 0, 32'h0040_0080, 0, 5'd0, 32'h1000_0004, 1, 0, 0);
`endif
        #2;
        reset_n = 1'b0;
        #1;
        push(32'h0040_0000, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        check("async_reset");
        @(negedge clock);
        reset_n = 1'b1;
        step("post_reset0", 1, 0, NOP, 0, 32'h0040_0004, 0, 5'd0, 32'd0, 0, 0, 0);
        step("post_reset1", 1, 0, NOP, 0, 32'h0040_0008, 0, 5'd0, 32'd0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
